fg_prog_sequencer: RTL

- Digital programming sequencer directly upstream of the floating-gate island.
- Accepts one program/read command at a time over a valid/ready handshake.
- Drives the row (vertical, 3-bit) and column (horizontal, 4-bit) VINJ decoder address/enable, the drain-select and prog-switch controls, and timed VINJ/VTUN pulse enables.
- Sequences settle, pulse, gap and release phases with cycle counters, so analog switches never change while a pulse is active.

---
 rtl/fg_prog_pkg.sv | 35 +++
 rtl/fg_prog_sequencer_timer.sv | 34 +++
 rtl/fg_prog_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fg_prog_pkg.sv
// fg_prog_pkg: shared types and constants for the floating-gate programming
// sequencer (command modes, FSM state codes, completion status codes).
package fg_prog_pkg;

   // Command mode as presented on cmd_mode.
   typedef enum logic [1:0] {
      MODE_INJECT  = 2'd0,
      MODE_TUNNEL  = 2'd1,
      MODE_READ    = 2'd2,
      MODE_ILLEGAL = 2'd3
   } mode_e;

   // Completion status reported alongside done.
   typedef enum logic [1:0] {
      STAT_OK          = 2'd0,
      STAT_ABORTED     = 2'd1,
      STAT_ZERO_PULSES = 2'd2,
      STAT_ILLEGAL     = 2'd3
   } status_e;

   // Sequencer state codes.
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_PULSE   = 3'd2;
   localparam logic [2:0] ST_GAP     = 3'd3;
   localparam logic [2:0] ST_HOLD    = 3'd4;
   localparam logic [2:0] ST_RELEASE = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;

   // True for the modes that fire VINJ/VTUN pulses.
   function automatic logic is_pulse_mode(input mode_e m);
      return (m == MODE_INJECT) || (m == MODE_TUNNEL);
   endfunction

endpackage

// File: rtl/fg_prog_sequencer_timer.sv
// fg_prog_timer: loadable down-counter shared by the settle, pulse, gap, hold
// and release phases. A phase of length L is loaded with L; expire is high
// during the last cycle of the phase (count == 1).
module fg_prog_timer #(
   parameter int unsigned WID_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WID_W-1:0] load_val,
   output logic             expire
);

   localparam logic [WID_W-1:0] ONE_W  = {{(WID_W-1){1'b0}}, 1'b1};
   localparam logic [WID_W-1:0] ZERO_W = {WID_W{1'b0}};

   logic [WID_W-1:0] count_r;

   // Load a new phase length or count the current phase down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= ZERO_W;
      end else if (load) begin
         count_r <= load_val;
      end else if (count_r != ZERO_W) begin
         count_r <= count_r - ONE_W;
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = (count_r == ONE_W);

endmodule

// File: rtl/fg_prog_sequencer.sv
// fg_prog_sequencer: accepts one program/read command at a time and sequences
// the VINJ decoder address/enable, prog/drain switch selects and the timed
// VINJ/VTUN pulse enables through settle, pulse, gap, hold and release phases.
// Switch and pulse outputs are registered from the phase the sequencer was in,
// so they trail the state by one cycle; pulse enables and the read strobe are
// additionally gated by abort so they drop on the cycle after abort.
// Optional feature: define FG_PROG_PULSE_LOG_EN to add the saturating
// pulse_total counter output.
module fg_prog_sequencer #(
   parameter int unsigned ROW_BITS   = 3,
   parameter int unsigned COL_BITS   = 4,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned WID_W      = 16,
   parameter int unsigned SETTLE_CYC = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_mode,
   input  logic [ROW_BITS-1:0] cmd_row,
   input  logic [COL_BITS-1:0] cmd_col,
   input  logic [CNT_W-1:0]    cmd_pulses,
   input  logic [WID_W-1:0]    cmd_width,
   input  logic                abort,
   output logic [ROW_BITS-1:0] row_addr,
   output logic [COL_BITS-1:0] col_addr,
   output logic                dec_en,
   output logic                prog_sel,
   output logic                drain_sel,
   output logic                vinj_pulse,
   output logic                vtun_en,
   output logic                meas_strobe,
   output logic                busy,
   output logic                done,
`ifdef FG_PROG_PULSE_LOG_EN
   output logic [15:0]         pulse_total,
`endif
   output logic [1:0]          status
);

   import fg_prog_pkg::*;

   localparam logic [WID_W-1:0] SETTLE_W = WID_W'(SETTLE_CYC);
   localparam logic [WID_W-1:0] ONE_W    = {{(WID_W-1){1'b0}}, 1'b1};
   localparam logic [WID_W-1:0] ZERO_W   = {WID_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};

   logic [2:0]       state_r;
   logic [2:0]       nxt_s;
   mode_e            mode_r;
   status_e          status_code_r;
   logic [CNT_W-1:0] pulses_left_r;
   logic [WID_W-1:0] width_r;
   logic [WID_W-1:0] width_eff_s;
   logic [WID_W-1:0] timer_val_s;
   logic             timer_load_s;
   logic             timer_exp_s;
   logic             accept_s;
   logic             cmd_illegal_s;
   logic             active_s;
   logic             abort_take_s;
   logic             zero_take_s;
   logic             pulse_end_s;
   logic             busy_nxt_s;

   assign accept_s      = cmd_valid && cmd_ready && (state_r == ST_IDLE);
   assign cmd_illegal_s = (mode_e'(cmd_mode) == MODE_ILLEGAL);
   assign active_s      = (state_r == ST_SETUP) || (state_r == ST_PULSE) ||
                          (state_r == ST_GAP)   || (state_r == ST_HOLD);
   assign abort_take_s  = abort && active_s;
   assign zero_take_s   = (state_r == ST_SETUP) && timer_exp_s && !abort &&
                          is_pulse_mode(mode_r) && (pulses_left_r == ZERO_C);
   assign pulse_end_s   = (state_r == ST_PULSE) && timer_exp_s && !abort;
   assign width_eff_s   = (width_r == ZERO_W) ? ONE_W : width_r;
   assign busy_nxt_s    = (nxt_s != ST_IDLE) || (state_r != ST_IDLE);

   fg_prog_timer #(
      .WID_W(WID_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load_s),
      .load_val(timer_val_s),
      .expire  (timer_exp_s)
   );

   // Next-state and phase-timer load selection.
   always_comb begin
      nxt_s        = state_r;
      timer_load_s = 1'b0;
      timer_val_s  = SETTLE_W;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (cmd_illegal_s) begin
                  nxt_s = ST_DONE;
               end else begin
                  nxt_s        = ST_SETUP;
                  timer_load_s = 1'b1;
                  timer_val_s  = SETTLE_W;
               end
            end else begin
               nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (abort) begin
               nxt_s        = ST_RELEASE;
               timer_load_s = 1'b1;
               timer_val_s  = SETTLE_W;
            end else if (timer_exp_s) begin
               if (mode_r == MODE_READ) begin
                  nxt_s        = ST_HOLD;
                  timer_load_s = 1'b1;
                  timer_val_s  = width_eff_s;
               end else if (pulses_left_r == ZERO_C) begin
                  nxt_s        = ST_RELEASE;
                  timer_load_s = 1'b1;
                  timer_val_s  = SETTLE_W;
               end else begin
                  nxt_s        = ST_PULSE;
                  timer_load_s = 1'b1;
                  timer_val_s  = width_eff_s;
               end
            end else begin
               nxt_s = ST_SETUP;
            end
         end
         ST_PULSE: begin
            if (abort) begin
               nxt_s        = ST_RELEASE;
               timer_load_s = 1'b1;
               timer_val_s  = SETTLE_W;
            end else if (timer_exp_s) begin
               nxt_s        = ST_GAP;
               timer_load_s = 1'b1;
               timer_val_s  = SETTLE_W;
            end else begin
               nxt_s = ST_PULSE;
            end
         end
         ST_GAP: begin
            if (abort) begin
               nxt_s        = ST_RELEASE;
               timer_load_s = 1'b1;
               timer_val_s  = SETTLE_W;
            end else if (timer_exp_s) begin
               if (pulses_left_r != ZERO_C) begin
                  nxt_s        = ST_PULSE;
                  timer_load_s = 1'b1;
                  timer_val_s  = width_eff_s;
               end else begin
                  nxt_s        = ST_RELEASE;
                  timer_load_s = 1'b1;
                  timer_val_s  = SETTLE_W;
               end
            end else begin
               nxt_s = ST_GAP;
            end
         end
         ST_HOLD: begin
            if (abort || timer_exp_s) begin
               nxt_s        = ST_RELEASE;
               timer_load_s = 1'b1;
               timer_val_s  = SETTLE_W;
            end else begin
               nxt_s = ST_HOLD;
            end
         end
         ST_RELEASE: begin
            if (timer_exp_s) begin
               nxt_s = ST_DONE;
            end else begin
               nxt_s = ST_RELEASE;
            end
         end
         ST_DONE: begin
            nxt_s = ST_IDLE;
         end
         default: begin
            nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= nxt_s;
      end
   end

   // Capture command fields and decoder address at acceptance; illegal
   // commands leave the decoder address untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_r   <= MODE_INJECT;
         width_r  <= ZERO_W;
         row_addr <= {ROW_BITS{1'b0}};
         col_addr <= {COL_BITS{1'b0}};
      end else if (accept_s) begin
         mode_r  <= mode_e'(cmd_mode);
         width_r <= cmd_width;
         if (!cmd_illegal_s) begin
            row_addr <= cmd_row;
            col_addr <= cmd_col;
         end
      end
   end

   // Remaining-pulse counter: loaded at accept, decremented as each pulse ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulses_left_r <= ZERO_C;
      end else if (accept_s) begin
         pulses_left_r <= cmd_pulses;
      end else if (pulse_end_s) begin
         pulses_left_r <= pulses_left_r - ONE_C;
      end
   end

   // Internal completion code, published on status when done fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_code_r <= STAT_OK;
      end else if (accept_s) begin
         status_code_r <= cmd_illegal_s ? STAT_ILLEGAL : STAT_OK;
      end else if (abort_take_s) begin
         status_code_r <= STAT_ABORTED;
      end else if (zero_take_s) begin
         status_code_r <= STAT_ZERO_PULSES;
      end
   end

   // Registered analog-control and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_en      <= 1'b0;
         prog_sel    <= 1'b0;
         drain_sel   <= 1'b0;
         vinj_pulse  <= 1'b0;
         vtun_en     <= 1'b0;
         meas_strobe <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         cmd_ready   <= 1'b1;
         status      <= 2'd0;
      end else begin
         dec_en      <= active_s;
         prog_sel    <= active_s && (mode_r != MODE_READ);
         drain_sel   <= active_s && (mode_r == MODE_INJECT);
         vinj_pulse  <= (state_r == ST_PULSE) && !abort && (mode_r == MODE_INJECT);
         vtun_en     <= (state_r == ST_PULSE) && !abort && (mode_r == MODE_TUNNEL);
         meas_strobe <= (state_r == ST_HOLD) && timer_exp_s && !abort;
         done        <= (state_r == ST_DONE);
         busy        <= busy_nxt_s;
         cmd_ready   <= !busy_nxt_s;
         if (state_r == ST_DONE) begin
            status <= status_code_r;
         end
      end
   end

`ifdef FG_PROG_PULSE_LOG_EN
   // Saturating count of pulses that ran their full width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_total <= 16'd0;
      end else if (pulse_end_s && (pulse_total != 16'hFFFF)) begin
         pulse_total <= pulse_total + 16'd1;
      end
   end
`endif

endmodule
